fpu_byte_link: RTL

Device-side front end of the 16-bit FPU's byte-serial tagged pin interface. It accepts tagged 8-bit bytes on `io_in`, assembles two 16-bit half-precision operands and a 4-bit opcode, and issues one operation to the FPU core. It then serializes the 16-bit result, optionally followed by a status byte, back out on `io_out` using the same tag format. It is the responder paired with the host/testbench driver and sits between the chip pins and the FPU datapath.

---
 rtl/fpu_byte_link.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_byte_link.sv
// fpu_byte_link: device-side byte-serial tagged pin front end for the 16-bit FPU core.
// Define FPU_LINK_STATUS_EN to append a tag-10 status byte after every result.
module fpu_byte_link (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out,
    output logic        ready,
    output logic        core_start,
    output logic [15:0] core_a,
    output logic [15:0] core_b,
    output logic [3:0]  core_op,
    input  logic        core_done,
    input  logic [15:0] core_result,
    input  logic [3:0]  core_flags
);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        TX_LO   = 3'd3,
        TX_HI   = 3'd4
`ifdef FPU_LINK_STATUS_EN
        , TX_ST = 3'd5
`endif
    } state_t;

    localparam logic [1:0]  TAG_IDLE   = 2'b00;
    localparam logic [1:0]  TAG_A      = 2'b01;
    localparam logic [1:0]  TAG_B      = 2'b10;
    localparam logic [1:0]  TAG_OP     = 2'b11;
    localparam logic [15:0] ERR_RESULT = 16'h7E00;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        a_ptr_q, a_ptr_d;
    logic        b_ptr_q, b_ptr_d;
    logic        a_cmp_q, a_cmp_d;
    logic        b_cmp_q, b_cmp_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic [11:0] io_out_q, io_out_d;
    logic        ready_q, ready_d;
    logic        start_q, start_d;

    logic [1:0]  in_tag;
    logic [7:0]  in_byte;
    logic        unused_pins;

    assign in_tag      = io_in[1:0];
    assign in_byte     = io_in[9:2];
    assign unused_pins = ^io_in[11:10];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        a_cmp_d = a_cmp_q;
        b_cmp_d = b_cmp_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;

        case (state_q)
            COLLECT: begin
                if (in_tag == TAG_A) begin
                    if (!a_ptr_q) begin
                        a_d[7:0] = in_byte;
                        a_ptr_d  = 1'b1;
                        a_cmp_d  = 1'b0;
                    end else begin
                        a_d[15:8] = in_byte;
                        a_ptr_d   = 1'b0;
                        a_cmp_d   = 1'b1;
                    end
                end else if (in_tag == TAG_B) begin
                    if (!b_ptr_q) begin
                        b_d[7:0] = in_byte;
                        b_ptr_d  = 1'b1;
                        b_cmp_d  = 1'b0;
                    end else begin
                        b_d[15:8] = in_byte;
                        b_ptr_d   = 1'b0;
                        b_cmp_d   = 1'b1;
                    end
                end else if (in_tag == TAG_OP) begin
                    if (a_cmp_q && b_cmp_q) begin
                        op_d    = in_byte[3:0];
                        state_d = ISSUE;
                    end else begin
                        // Opcode without two full operands: answer with a NaN and the error bit.
                        res_d   = ERR_RESULT;
                        flags_d = 4'h0;
                        err_d   = 1'b1;
                        state_d = TX_LO;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (core_done) begin
                    res_d   = core_result;
                    flags_d = core_flags;
                    err_d   = 1'b0;
                    state_d = TX_LO;
                end
            end
            TX_LO: state_d = TX_HI;
`ifdef FPU_LINK_STATUS_EN
            TX_HI: state_d = TX_ST;
            TX_ST: state_d = COLLECT;
`else
            TX_HI: state_d = COLLECT;
`endif
            default: state_d = COLLECT;
        endcase

        // A new transaction always starts with empty operand byte pointers.
        if (state_d == COLLECT && state_q != COLLECT) begin
            a_ptr_d = 1'b0;
            b_ptr_d = 1'b0;
            a_cmp_d = 1'b0;
            b_cmp_d = 1'b0;
        end

        ready_d  = (state_d == COLLECT);
        start_d  = (state_d == ISSUE);
        io_out_d = 12'h000;
        case (state_d)
            TX_LO:   io_out_d = {2'b00, res_d[7:0], TAG_A};
            TX_HI:   io_out_d = {2'b00, res_d[15:8], TAG_A};
`ifdef FPU_LINK_STATUS_EN
            TX_ST:   io_out_d = {2'b00, err_d, 3'b000, flags_d, TAG_B};
`endif
            default: io_out_d = {10'h000, TAG_IDLE};
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= COLLECT;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            a_ptr_q  <= 1'b0;
            b_ptr_q  <= 1'b0;
            a_cmp_q  <= 1'b0;
            b_cmp_q  <= 1'b0;
            op_q     <= 4'h0;
            res_q    <= 16'h0000;
            flags_q  <= 4'h0;
            err_q    <= 1'b0;
            io_out_q <= 12'h000;
            ready_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            a_cmp_q  <= a_cmp_d;
            b_cmp_q  <= b_cmp_d;
            op_q     <= op_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            io_out_q <= io_out_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
        end
    end

    assign io_out     = io_out_q;
    assign ready      = ready_q;
    assign core_start = start_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_op    = op_q;

endmodule
